// File: rtl/apu_pkg.sv
// Shared APU constants and helpers: default envelope geometry, decay ceiling
// and flat-bus channel slicing.
package apu_pkg;

  localparam int DEFAULT_NUM_CH    = 4;
  localparam int DEFAULT_VOL_WIDTH = 4;

  function automatic int decay_max(input int width);
    return (1 << width) - 1;
  endfunction

  // LSB of channel ch inside a flat bus of width-bit fields
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/envelope_channel.sv
// One envelope unit: restart latch, divider and decay counter, plus the
// registered volume and silence outputs for a single channel.
module envelope_channel
  import apu_pkg::*;
#(
  parameter int VOL_WIDTH = DEFAULT_VOL_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic                 i_start,
  input  logic [VOL_WIDTH-1:0] i_rate,
  input  logic                 i_loop,
  input  logic                 i_constant,
  output logic [VOL_WIDTH-1:0] o_data,
  output logic                 o_silent
);

  localparam logic [VOL_WIDTH-1:0] DECAY_MAX = VOL_WIDTH'(decay_max(VOL_WIDTH));
  localparam logic [VOL_WIDTH-1:0] ONE       = VOL_WIDTH'(1);

  logic                 r_start_flag;
  logic [VOL_WIDTH-1:0] r_divider;
  logic [VOL_WIDTH-1:0] r_decay;
  logic [VOL_WIDTH-1:0] r_data;
  logic                 r_silent;

  logic                 w_eff_start;
  logic                 w_start_next;
  logic [VOL_WIDTH-1:0] w_divider_next;
  logic [VOL_WIDTH-1:0] w_decay_next;

  // A start seen on the same cycle as the tick counts as already latched
  assign w_eff_start = r_start_flag | i_start;

  always_comb begin
    w_start_next   = w_eff_start;
    w_divider_next = r_divider;
    w_decay_next   = r_decay;
    if (i_tick) begin
      w_start_next = 1'b0;
      if (w_eff_start) begin
        w_decay_next   = DECAY_MAX;
        w_divider_next = i_rate;
      end else if (r_divider == '0) begin
        w_divider_next = i_rate;
        if (r_decay != '0) begin
          w_decay_next = r_decay - ONE;
        end else if (i_loop) begin
          w_decay_next = DECAY_MAX;
        end
      end else begin
        w_divider_next = r_divider - ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start_flag <= 1'b0;
      r_divider    <= '0;
      r_decay      <= DECAY_MAX;
      r_data       <= '0;
      r_silent     <= 1'b0;
    end else begin
      r_start_flag <= w_start_next;
      r_divider    <= w_divider_next;
      r_decay      <= w_decay_next;
      r_data       <= i_constant ? i_rate : w_decay_next;
      r_silent     <= (w_decay_next == '0) & ~i_loop & ~i_constant;
    end
  end

  assign o_data   = r_data;
  assign o_silent = r_silent;

endmodule

// File: rtl/envelope_generator_multi.sv
// Multi-channel envelope generator: slices the flat per-channel buses and
// shares the quarter-frame tick across independent envelope_channel units.
module envelope_generator_multi
  import apu_pkg::*;
#(
  parameter int NUM_CH    = DEFAULT_NUM_CH,
  parameter int VOL_WIDTH = DEFAULT_VOL_WIDTH
) (
  input  logic                        iClk,
  input  logic                        iReset_n,
  input  logic                        iEnvelope_clk,
  input  logic [NUM_CH-1:0]           iStart,
  input  logic [NUM_CH*VOL_WIDTH-1:0] iVolume_or_decay_rate,
  input  logic [NUM_CH-1:0]           iEnable_loop,
  input  logic [NUM_CH-1:0]           iConstant,
  output logic [NUM_CH*VOL_WIDTH-1:0] oData,
  output logic [NUM_CH-1:0]           oSilent
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam int LSB = ch_lsb(gi, VOL_WIDTH);

      envelope_channel #(
        .VOL_WIDTH (VOL_WIDTH)
      ) u_ch (
        .i_clk      (iClk),
        .i_rst_n    (iReset_n),
        .i_tick     (iEnvelope_clk),
        .i_start    (iStart[gi]),
        .i_rate     (iVolume_or_decay_rate[LSB +: VOL_WIDTH]),
        .i_loop     (iEnable_loop[gi]),
        .i_constant (iConstant[gi]),
        .o_data     (oData[LSB +: VOL_WIDTH]),
        .o_silent   (oSilent[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_envelope_generator_multi.sv
// Directed bench for envelope_generator_multi: a vector table for the
// interleaved 4-channel behaviour plus sequences for long multi-tick cases.
module tb_envelope_generator_multi;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  start = '0;
  logic [15:0] rate = '0;
  logic [3:0]  loop_en = '0;
  logic [3:0]  cnst = '0;
  logic [15:0] data;
  logic [3:0]  sil;

  logic        tick8 = 1'b0;
  logic [7:0]  start8 = '0;
  logic [47:0] rate8 = '0;
  logic [7:0]  loop8 = '0;
  logic [7:0]  cnst8 = '0;
  logic [47:0] data8;
  logic [7:0]  sil8;

  int total = 0;
  int bad = 0;

  envelope_generator_multi dut (
    .iClk                  (iClk),
    .iReset_n              (iReset_n),
    .iEnvelope_clk         (tick),
    .iStart                (start),
    .iVolume_or_decay_rate (rate),
    .iEnable_loop          (loop_en),
    .iConstant             (cnst),
    .oData                 (data),
    .oSilent               (sil)
  );

  envelope_generator_multi #(.NUM_CH(8), .VOL_WIDTH(6)) dut8 (
    .iClk                  (iClk),
    .iReset_n              (iReset_n),
    .iEnvelope_clk         (tick8),
    .iStart                (start8),
    .iVolume_or_decay_rate (rate8),
    .iEnable_loop          (loop8),
    .iConstant             (cnst8),
    .oData                 (data8),
    .oSilent               (sil8)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic        tick;
    logic [3:0]  start;
    logic [15:0] exp_data;
    logic [3:0]  exp_sil;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic tk, input logic [3:0] st);
    tick  = tk;
    start = st;
    @(posedge iClk);
    #1;
    tick  = 1'b0;
    start = '0;
    $display("step tick=%b start=%b data=%h sil=%b", tk, st, data, sil);
  endtask

  task automatic step8(input logic tk, input logic [7:0] st);
    tick8  = tk;
    start8 = st;
    @(posedge iClk);
    #1;
    tick8  = 1'b0;
    start8 = '0;
    $display("step8 tick=%b start=%b data=%h sil=%b", tk, st, data8, sil8);
  endtask

  // Expected 8-channel bus: ch5 constant 33, ch3 and ch7 special, rest common
  function automatic logic [47:0] exp8(input int common, input int v3, input int v7);
    logic [47:0] r;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      if (c == 5)      r[c*6 +: 6] = 6'd33;
      else if (c == 3) r[c*6 +: 6] = 6'(v3);
      else if (c == 7) r[c*6 +: 6] = 6'(v7);
      else             r[c*6 +: 6] = 6'(common);
    end
    return r;
  endfunction

  initial begin
    int exp_v;

    // ch0 rate3, ch1 rate0 loop, ch2 rate1, ch3 constant 9
    rate    = {4'd9, 4'd1, 4'd0, 4'd3};
    loop_en = 4'b0010;
    cnst    = 4'b1000;
    rate8   = '0;
    rate8[5*6 +: 6] = 6'd33;
    rate8[7*6 +: 6] = 6'd1;
    cnst8   = 8'b0010_0000;

    vecs[0]  = '{1'b0, 4'b0000, 16'h9FFF, 4'h0};
    vecs[1]  = '{1'b1, 4'b0000, 16'h9EEE, 4'h0};
    vecs[2]  = '{1'b1, 4'b0000, 16'h9EDE, 4'h0};
    vecs[3]  = '{1'b1, 4'b0000, 16'h9DCE, 4'h0};
    vecs[4]  = '{1'b0, 4'b0001, 16'h9DCE, 4'h0};
    vecs[5]  = '{1'b0, 4'b0001, 16'h9DCE, 4'h0};
    vecs[6]  = '{1'b1, 4'b0000, 16'h9DBF, 4'h0};
    vecs[7]  = '{1'b1, 4'b0000, 16'h9CAF, 4'h0};
    vecs[8]  = '{1'b1, 4'b0100, 16'h9F9F, 4'h0};
    vecs[9]  = '{1'b1, 4'b0000, 16'h9F8F, 4'h0};
    vecs[10] = '{1'b1, 4'b0000, 16'h9E7E, 4'h0};

    repeat (3) @(posedge iClk);
    #1;
    chk("reset_data", 64'(data), 64'h0);
    chk("reset_sil", 64'(sil), 64'h0);
    chk("reset_data8", 64'(data8), 64'h0);
    chk("reset_sil8", 64'(sil8), 64'h0);
    iReset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].tick, vecs[i].start);
      chk($sformatf("vec%0d_data", i), 64'(data), 64'(vecs[i].exp_data));
      chk($sformatf("vec%0d_sil", i), 64'(sil), 64'(vecs[i].exp_sil));
    end

    // Wide instance: still at reset state, then per-channel independence
    step8(1'b0, 8'h00);
    chk("w8_first", 64'(data8), 64'(exp8(63, 63, 63)));
    step8(1'b1, 8'b0000_1000);
    chk("w8_tick1", 64'(data8), 64'(exp8(62, 63, 62)));
    step8(1'b1, 8'h00);
    chk("w8_tick2", 64'(data8), 64'(exp8(61, 62, 62)));
    chk("w8_sil", 64'(sil8), 64'h0);

    // ch0 rate2 no loop: one decay step every 3 ticks down to silence
    rate[3:0] = 4'd2;
    step(1'b0, 4'b0001);
    for (int k = 1; k <= 49; k++) begin
      step(1'b1, 4'b0000);
      exp_v = (k <= 46) ? 15 - (k - 1) / 3 : 0;
      chk($sformatf("ch0_tick%0d", k), 64'(data[3:0]), 64'(exp_v));
      chk($sformatf("ch0_sil%0d", k), 64'(sil[0]), 64'(exp_v == 0));
    end

    // ch1 rate0 loop: 15 down to 0 then wraps to 15, never silent
    step(1'b0, 4'b0010);
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 4'b0000);
      exp_v = (k <= 16) ? 16 - k : 15;
      chk($sformatf("ch1_tick%0d", k), 64'(data[7:4]), 64'(exp_v));
      chk($sformatf("ch1_sil%0d", k), 64'(sil[1]), 64'h0);
    end

    // ch2: restart with start and tick together while decay is 5
    rate[11:8] = 4'd0;
    step(1'b1, 4'b0100);
    repeat (10) step(1'b1, 4'b0000);
    chk("ch2_at5", 64'(data[11:8]), 64'd5);
    step(1'b1, 4'b0100);
    chk("ch2_restart", 64'(data[11:8]), 64'd15);
    step(1'b1, 4'b0000);
    chk("ch2_no_rerestart", 64'(data[11:8]), 64'd14);

    // ch3 constant volume hides the envelope until constant is cleared
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b0000);
      chk("ch3_const9", 64'(data[15:12]), 64'd9);
    end
    rate[15:12] = 4'd0;
    step(1'b0, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b0000);
      chk("ch3_const0", 64'(data[15:12]), 64'd0);
    end
    cnst[3] = 1'b0;
    step(1'b0, 4'b0000);
    chk("ch3_decay13", 64'(data[15:12]), 64'd13);
    chk("ch3_sil", 64'(sil[3]), 64'h0);

    // Asynchronous reset mid-countdown on ch0
    rate[3:0] = 4'd0;
    step(1'b1, 4'b0001);
    repeat (8) step(1'b1, 4'b0000);
    chk("ch0_at7", 64'(data[3:0]), 64'd7);
    iReset_n = 1'b0;
    #2;
    chk("async_rst_data", 64'(data), 64'h0);
    chk("async_rst_sil", 64'(sil), 64'h0);
    chk("async_rst_data8", 64'(data8), 64'h0);
    @(posedge iClk);
    #1;
    iReset_n = 1'b1;
    step(1'b0, 4'b0000);
    chk("post_rst_data", 64'(data), 64'hFFFF);
    chk("post_rst_sil", 64'(sil), 64'h0);
    step8(1'b0, 8'h00);
    chk("post_rst_data8", 64'(data8), 64'(exp8(63, 63, 63)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/envelope_generator_multi.md
# envelope_generator_multi

Parametrised, multi-channel envelope generator for the APU: one independent envelope unit per channel, all clocked by the shared quarter-frame tick. It adds a per-channel start/restart flag, per-channel constant-volume mode, and a silence status output. Outputs are registered volume levels that feed the channel mixers. It replaces per-channel single-envelope instances in the pulse and noise paths.

## Interface
- NUM_CH, 4, number of envelope channels (1..8)
- VOL_WIDTH, 4, width of the volume, decay-rate and level fields
- iClk  in  1  system clock
- iReset_n  in  1  asynchronous, active-low reset
- iEnvelope_clk  in  1  quarter-frame tick; single-cycle pulse shared by all channels
- iStart  in  NUM_CH  per-channel restart pulse, driven by a length/volume register write
- iVolume_or_decay_rate  in  NUM_CH*VOL_WIDTH  per-channel constant volume or divider period; channel c uses bits [c*VOL_WIDTH +: VOL_WIDTH]
- iEnable_loop  in  NUM_CH  per-channel loop enable
- iConstant  in  NUM_CH  per-channel constant-volume select
- oData  out  NUM_CH*VOL_WIDTH  per-channel output volume, registered
- oSilent  out  NUM_CH  per-channel flag: decay level 0 and no loop, registered

## Operation
- Per-channel state:
  - start_flag (1 bit)
  - divider (VOL_WIDTH bits)
  - decay (VOL_WIDTH bits)
- DECAY_MAX = 2^VOL_WIDTH − 1.
- Effective start: eff_start = start_flag | iStart[c].
- Cycle without tick: start_flag <= eff_start. divider and decay hold.
- Cycle with tick, eff_start = 1:
  - start_flag <= 0
  - decay <= DECAY_MAX
  - divider <= rate
- Cycle with tick, eff_start = 0 and divider = 0:
  - divider <= rate
  - if decay ≠ 0: decay <= decay − 1
  - if decay = 0 and loop = 1: decay <= DECAY_MAX
  - if decay = 0 and loop = 0: decay holds at 0
- Cycle with tick, eff_start = 0 and divider ≠ 0: divider <= divider − 1.
- Decay therefore steps once every rate+1 ticks. With rate = 0 it steps on every tick.
- Output: oData[c] <= iConstant[c] ? rate[c] : next decay[c].
- Silence: oSilent[c] <= (next decay = 0) & ~iEnable_loop[c] & ~iConstant[c].
- Channels are fully independent. All channels share only the tick.
- A change to rate is picked up at the next divider reload, not mid-count.
- Arithmetic is unsigned VOL_WIDTH. Decrement never wraps: the zero case is handled explicitly.

## Timing
- Reset values (asynchronous, while iReset_n = 0):
  - start_flag = 0
  - divider = 0
  - decay = DECAY_MAX
  - oData = 0
  - oSilent = 0
- Reset asserted mid-countdown aborts immediately. After release, all channels restart from reset values.
- First iClk edge after release: oData = constant ? rate : DECAY_MAX.
- Latency: tick, start or input change sampled at edge t appears on oData/oSilent after edge t, i.e. one cycle.
- iStart and tick in the same cycle: restart is applied on that tick, and start_flag ends at 0.
- iStart without a tick: start_flag is latched until the next tick. Repeated iStart before that tick has no extra effect.
- iStart with iConstant = 1: state still restarts, so switching back to decay mode shows the restarted envelope.
- iEnvelope_clk held high for several cycles counts as one tick per cycle. Drivers must pulse it.

## Structure
- Shared package apu_pkg holds:
  - DECAY_MAX derivation
  - channel-slice helper constants
  - default NUM_CH / VOL_WIDTH
- Natural sub-module: envelope_channel, one per channel via generate. It holds start_flag, divider, decay, and the oData/oSilent registers.
- The top level slices the flat buses and fans out iEnvelope_clk only.

## Test plan
- Reset with rate = 3, loop = 0, const = 0 → oData = 15, oSilent = 0 after release; ticks without start leave decay at 15 until divider reaches 0, then decay goes to 14.
- Ch0 rate = 2, loop = 0: iStart, then 1 tick → oData = 15; ticks 2–3 → 15; tick 4 → 14; after 46 total ticks → 0 and oSilent = 1, staying 0 on further ticks.
- Ch1 rate = 0, loop = 1: start + 16 ticks → sequence 15, 14, …, 0; 17th tick → 15 and oSilent stays 0.
- iStart and tick in the same cycle while ch2 decay = 5 → next cycle oData = 15, and the following tick does not restart again.
- Ch3 const = 1, rate = 9 → oData = 9 regardless of ticks; clear const after 3 ticks following start with rate = 0 → oData = 13.
- Assert iReset_n mid-countdown (decay = 7) → oData = 0 immediately, then 15 after release; other channels are checked independent with NUM_CH = 8, VOL_WIDTH = 6 (DECAY_MAX = 63).
